// File: rtl/demux_buffer.sv
// demux_buffer: distributes words from a single input bus into CHANNELS
// channel registers.
//
// Write modes:
//   - Addressed (mode = 0): the word goes to the channel named by selector.
//   - Sequential (mode = 1): the word goes to the channel named by an
//     internal pointer, which then advances and wraps.
//
// Once every channel has been written, the FSM enters FULL. In FULL, done
// pulses for one cycle and sequential writes are refused. Addressed
// overwrites are still accepted in FULL.
//
// Ports:
//   clk           - single clock, rising edge
//   reset         - synchronous active-low reset (zeros data, flags, pointer)
//   clear         - synchronous soft clear of flags/pointer; data retained
//   mode          - 0 addressed, 1 sequential
//   selector      - target channel in addressed mode
//   valid         - data_in carries a word this cycle
//   data_in       - word to distribute
//   ready         - a word offered with valid is accepted this cycle
//   data_out      - channel i at [BUS_SIZE*i +: BUS_SIZE]
//   channel_valid - bit i set once channel i is written since reset/clear
//   done          - one-cycle pulse when channel_valid becomes all ones
//   pointer       - current sequential-mode target channel
`ifndef ARQUITECTURE_BITS
`define ARQUITECTURE_BITS 32
`endif

module demux_buffer #(
    parameter int CHANNELS = 4,
    parameter int BUS_SIZE = `ARQUITECTURE_BITS,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             selector,
    input  logic                         valid,
    input  logic [BUS_SIZE-1:0]          data_in,
    output logic                         ready,
    output logic [CHANNELS*BUS_SIZE-1:0] data_out,
    output logic [CHANNELS-1:0]          channel_valid,
    output logic                         done,
    output logic [SEL_W-1:0]             pointer
);

    typedef enum logic {S_OPEN = 1'b0, S_FULL = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [CHANNELS-1:0] r_chv, w_chv_nxt;
    logic [SEL_W-1:0]    r_ptr, w_ptr_nxt, w_tgt;
    logic                r_done, w_done_nxt;
    logic                w_ready, w_wr_en;

    // Sequential writes are refused once full; addressed overwrites never are.
    assign w_ready = (r_state == S_OPEN) || !mode;

    always_comb begin
        w_tgt       = mode ? r_ptr : selector;
        // Out-of-range selectors (non power-of-two CHANNELS) are silently dropped.
        w_wr_en     = valid && w_ready && !clear &&
                      (mode || (32'(selector) < CHANNELS));
        w_chv_nxt   = r_chv;
        w_ptr_nxt   = r_ptr;
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;

        if (clear) begin
            w_chv_nxt = '0;
            w_ptr_nxt = '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < CHANNELS; i++)
                if (w_tgt == SEL_W'(i)) w_chv_nxt[i] = 1'b1;
            if (mode)
                w_ptr_nxt = (r_ptr == SEL_W'(CHANNELS - 1)) ? '0 : r_ptr + SEL_W'(1);
        end

        unique case (r_state)
            S_OPEN: if (!clear && (&w_chv_nxt)) begin
                w_state_nxt = S_FULL;
                w_done_nxt  = 1'b1;
            end
            S_FULL: if (clear) w_state_nxt = S_OPEN;
            default: w_state_nxt = S_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_OPEN;
            r_chv   <= '0;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chv   <= w_chv_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [BUS_SIZE-1:0] r_word;
        always_ff @(posedge clk) begin
            if (!reset)
                r_word <= '0;
            else if (w_wr_en && (w_tgt == SEL_W'(g)))
                r_word <= data_in;
        end
        assign data_out[g*BUS_SIZE +: BUS_SIZE] = r_word;
    end

    assign ready         = w_ready;
    assign channel_valid = r_chv;
    assign done          = r_done;
    assign pointer       = r_ptr;

endmodule

// File: doc/demux_buffer.md
DEMUX_BUFFER -- requirements
Module: demux_buffer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of output channels (2..16).
REQ-002 SHALL have parameter BUS_SIZE, default `ARQUITECTURE_BITS (32), width of one channel word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port clear  input  1  synchronous soft clear of flags and pointer; data is not cleared.
REQ-006 SHALL have port mode  input  1  0 = addressed write, 1 = sequential write via internal pointer.
REQ-007 SHALL have port selector  input  $clog2(CHANNELS)  target channel in addressed mode; ignored in sequential mode.
REQ-008 SHALL have port valid  input  1  data_in carries a word to store this cycle.
REQ-009 SHALL have port data_in  input  BUS_SIZE  word to distribute.
REQ-010 SHALL have port ready  output  1  a word offered with valid is accepted this cycle.
REQ-011 SHALL have port data_out  output  CHANNELS*BUS_SIZE  concatenated channel registers; channel i at bits [BUS_SIZE*i +: BUS_SIZE].
REQ-012 SHALL have port channel_valid  output  CHANNELS  bit i = channel i written since last reset/clear.
REQ-013 SHALL have port done  output  1  one-cycle pulse when channel_valid becomes all ones.
REQ-014 SHALL have port pointer  output  $clog2(CHANNELS)  current sequential-mode target channel.

Function
REQ-015 SHALL implement a two-state FSM: OPEN (not all channels valid) and FULL (all channels valid).
REQ-016 SHALL drive ready = 1 in OPEN; in FULL, ready = 1 only when mode = 0, else 0.
REQ-017 SHALL accept a word when valid & ready; accepted word written to its channel register on that rising edge, visible on data_out the next cycle (latency 1).
REQ-018 SHALL, in addressed mode, write channel selector and set channel_valid[selector]; pointer unchanged.
REQ-019 SHALL, in sequential mode, write channel pointer, set channel_valid[pointer], and increment pointer, wrapping CHANNELS-1 -> 0.
REQ-020 SHALL ignore addressed writes with selector >= CHANNELS: no data, flag, or state change; ready unaffected.
REQ-021 SHALL leave non-targeted channel registers and flags unchanged on every write.
REQ-022 SHALL overwrite an already-valid channel in addressed mode without any flag or error indication.
REQ-023 SHALL transition OPEN -> FULL on the edge where the accepted write makes channel_valid all ones, and pulse done high for exactly the following cycle.
REQ-024 SHALL not pulse done again while in FULL, including on addressed overwrites.
REQ-025 SHALL, on clear = 1, zero channel_valid and pointer, go to OPEN, keep data_out contents, and drop any write offered that cycle (clear wins over valid).
REQ-026 SHALL retain pointer and channel_valid across mode changes; mode is sampled per cycle.
REQ-027 SHALL hold all outputs stable when valid = 0 and clear = 0.

Reset
REQ-028 SHALL, when reset = 0 at a rising edge, set data_out = 0, channel_valid = 0, pointer = 0, done = 0, FSM = OPEN; reset overrides clear and valid.
REQ-029 SHALL, mid-fill, abandon the fill on reset with no done pulse; the first accepted sequential write after release targets channel 0.

Verification (CHANNELS=4, BUS_SIZE=32)
REQ-030 SHALL check reset: reset low 2 cycles with valid=1 -> data_out=0, channel_valid=4'b0000, pointer=0, done=0, ready=1.
REQ-031 SHALL check sequential fill: mode=1, valid=1 for 4 cycles with data 0xA0..0xA3 -> channels 0..3 = 0xA0..0xA3, done high one cycle after 4th write, then ready=0, 5th word 0xFF not stored, pointer=0.
REQ-032 SHALL check addressed writes: mode=0, selector=2 data 0x1234, then selector=0 data 0x5678 -> channel_valid=4'b0101, channel2=0x1234, channel0=0x5678, channels 1,3 unchanged, no done.
REQ-033 SHALL check FULL overwrite: after REQ-031, mode=0 selector=1 data 0xBEEF -> ready=1, channel1=0xBEEF, no second done pulse.
REQ-034 SHALL check clear priority: clear=1 with valid=1 mode=1 data 0x77 -> channel_valid=0, pointer=0, data_out unchanged, 0x77 not stored, FSM OPEN (ready=1 with mode=1).
REQ-035 SHALL check reset mid-fill: 2 sequential writes, reset low 1 cycle, then 1 sequential write 0x99 -> channel0=0x99, channel_valid=4'b0001, pointer=1, no done.
